// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory responder slice.
// Holds the responder FSM state type, default bus widths and the wait counter width.
package mem_if_pkg;

   localparam int unsigned ADDR_W_DEF = 16;
   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned CNT_W      = 4;   // wide enough for WAIT_STATES up to 15

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StAccess,
      StResp
   } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the control unit (master) and the memory responder (slave).
// Request channel : req_valid/req_ready handshake carrying req_write, req_addr, req_wdata.
// Response channel: resp_valid/resp_ready handshake carrying resp_rdata, resp_error.
interface mem_responder_if #(
   parameter int unsigned ADDR_W = mem_if_pkg::ADDR_W_DEF,
   parameter int unsigned DATA_W = mem_if_pkg::DATA_W_DEF
) ();

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_error;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_error
   );

endinterface

// File: rtl/mem_array.sv
// Word-addressed storage array for the memory responder.
// Ports: clk_i (clock), we_i (write enable), addr_i (word address), wdata_i (write data),
//        rdata_o (asynchronous read of addr_i).
// Contents have no reset.
module mem_array #(
   parameter int unsigned DEPTH  = 16384,
   parameter int unsigned DATA_W = 16,
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one read/write request at a time, waits WAIT_STATES cycles,
// performs the access on mem_array and holds the response until the initiator takes it.
// Ports: clock (rising edge), reset (synchronous, active high),
//        bus_io (slave side of mem_responder_if: request and response channels).
module mem_responder
   import mem_if_pkg::*;
#(
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned DEPTH       = 16384,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic           clock,
   input  logic           reset,
   mem_responder_if.slave bus_io
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so DEPTH == 2**ADDR_W is representable; range check uses full address.
   localparam logic [ADDR_W:0]  DepthExt  = DEPTH[ADDR_W:0];
   localparam logic [CNT_W-1:0] WaitLoad  = WAIT_STATES[CNT_W-1:0];

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              error_q, error_d;
   logic              valid_q, valid_d;

   logic              in_range;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   assign in_range = ({1'b0, addr_q} < DepthExt);

   mem_array #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_mem_array (
      .clk_i   (clock),
      .we_i    (mem_we),
      .addr_i  (addr_q[AW-1:0]),
      .wdata_i (wdata_q),
      .rdata_o (mem_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      error_d = error_q;
      valid_d = valid_q;
      mem_we  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus_io.req_valid) begin
               write_d = bus_io.req_write;
               addr_d  = bus_io.req_addr;
               wdata_d = bus_io.req_wdata;
               cnt_d   = WaitLoad;
               state_d = (WAIT_STATES == 0) ? StAccess : StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
               state_d = StAccess;
            end
         end
         StAccess: begin
            valid_d = 1'b1;
            if (!in_range) begin
               error_d = 1'b1;
               rdata_d = '0;
            end else if (write_q) begin
               error_d = 1'b0;
               rdata_d = '0;
               mem_we  = 1'b1;
            end else begin
               error_d = 1'b0;
               rdata_d = mem_rdata;
            end
            state_d = StResp;
         end
         StResp: begin
            // rdata is left as-is; it is only meaningful while resp_valid is high.
            if (bus_io.resp_ready) begin
               valid_d = 1'b0;
               error_d = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         error_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         error_q <= error_d;
         valid_q <= valid_d;
      end
   end

   assign bus_io.req_ready  = (state_q == StIdle);
   assign bus_io.resp_valid = valid_q;
   assign bus_io.resp_rdata = rdata_q;
   assign bus_io.resp_error = error_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: two instances (WAIT_STATES = 2 and 0) driven by
// directed and random transactions, checked against an array model of memory contents.
module tb_mem_responder;

   localparam int unsigned Depth = 16384;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic [1:0]  rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_write;
   logic [1:0]  resp_ready;
   logic [15:0] req_addr  [2];
   logic [15:0] req_wdata [2];
   logic [1:0]  o_req_ready;
   logic [1:0]  o_resp_valid;
   logic [1:0]  o_resp_error;
   logic [15:0] o_rdata   [2];

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [15:0] mem_model [2][Depth];
   bit          known     [2][Depth];

   mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();
   mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

   assign bus0.req_valid  = req_valid[0];
   assign bus0.req_write  = req_write[0];
   assign bus0.req_addr   = req_addr[0];
   assign bus0.req_wdata  = req_wdata[0];
   assign bus0.resp_ready = resp_ready[0];
   assign bus1.req_valid  = req_valid[1];
   assign bus1.req_write  = req_write[1];
   assign bus1.req_addr   = req_addr[1];
   assign bus1.req_wdata  = req_wdata[1];
   assign bus1.resp_ready = resp_ready[1];

   assign o_req_ready[0]  = bus0.req_ready;
   assign o_resp_valid[0] = bus0.resp_valid;
   assign o_resp_error[0] = bus0.resp_error;
   assign o_rdata[0]      = bus0.resp_rdata;
   assign o_req_ready[1]  = bus1.req_ready;
   assign o_resp_valid[1] = bus1.resp_valid;
   assign o_resp_error[1] = bus1.resp_error;
   assign o_rdata[1]      = bus1.resp_rdata;

   mem_responder #(
      .ADDR_W      (16),
      .DATA_W      (16),
      .DEPTH       (Depth),
      .WAIT_STATES (2)
   ) u_dut_ws2 (
      .clock  (clock),
      .reset  (rst[0]),
      .bus_io (bus0)
   );

   mem_responder #(
      .ADDR_W      (16),
      .DATA_W      (16),
      .DEPTH       (Depth),
      .WAIT_STATES (0)
   ) u_dut_ws0 (
      .clock  (clock),
      .reset  (rst[1]),
      .bus_io (bus1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int wait_states(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   // Present a request at a point just after a rising edge; returns just after the accept edge
   // with the request inputs scrambled so late changes would be visible.
   task automatic issue(input int d, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wdata);
      check("req_ready_idle", 32'(o_req_ready[d]), 32'd1);
      req_write[d] = wr;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      req_valid[d] = 1'b1;
      @(posedge clock);
      #1;
      req_valid[d] = 1'b0;
      req_write[d] = 1'($urandom);
      req_addr[d]  = 16'($urandom);
      req_wdata[d] = 16'($urandom);
   endtask

   // Wait for the response, check it, hold off resp_ready for 'hold' cycles, then handshake.
   // With 'offer' set, a read of offer_addr is presented during the hold and is accepted on
   // the edge after the handshake.
   task automatic collect(input int d, input int exp_lat, input logic [15:0] exp_rdata,
                          input bit exp_err, input bit chk_rdata, input int hold,
                          input bit offer, input logic [15:0] offer_addr);
      int lat = 0;
      do begin
         @(posedge clock);
         #1;
         lat++;
      end while (!o_resp_valid[d] && lat < 40);
      check("resp_valid_seen", 32'(o_resp_valid[d]), 32'd1);
      check("latency", 32'(lat), 32'(exp_lat));
      check("resp_error", 32'(o_resp_error[d]), 32'(exp_err));
      if (chk_rdata) check("resp_rdata", 32'(o_rdata[d]), 32'(exp_rdata));
      for (int i = 0; i < hold; i++) begin
         if (offer) begin
            req_write[d] = 1'b0;
            req_addr[d]  = offer_addr;
            req_valid[d] = 1'b1;
         end
         check("req_ready_in_resp", 32'(o_req_ready[d]), 32'd0);
         @(posedge clock);
         #1;
         check("hold_valid", 32'(o_resp_valid[d]), 32'd1);
         check("hold_error", 32'(o_resp_error[d]), 32'(exp_err));
         if (chk_rdata) check("hold_rdata", 32'(o_rdata[d]), 32'(exp_rdata));
      end
      resp_ready[d] = 1'b1;
      @(posedge clock);
      #1;
      resp_ready[d] = 1'b0;
      check("resp_valid_clear", 32'(o_resp_valid[d]), 32'd0);
      check("resp_error_clear", 32'(o_resp_error[d]), 32'd0);
      if (offer) begin
         check("req_ready_after_hs", 32'(o_req_ready[d]), 32'd1);
         @(posedge clock);
         #1;
         req_valid[d] = 1'b0;
      end
   endtask

   // Full transaction with expectations taken from the memory model.
   task automatic txn(input int d, input bit wr, input logic [15:0] addr,
                      input logic [15:0] wdata, input int hold);
      logic [15:0] er;
      bit          ee;
      bit          cr;
      ee = (32'(addr) >= Depth);
      cr = 1'b1;
      er = 16'h0000;
      if (!ee) begin
         if (wr) begin
            mem_model[d][addr] = wdata;
            known[d][addr]     = 1'b1;
         end else begin
            er = mem_model[d][addr];
            cr = known[d][addr];
         end
      end
      issue(d, wr, addr, wdata);
      collect(d, 1 + wait_states(d), er, ee, cr, hold, 1'b0, 16'h0000);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] pool [9];
      rst        = 2'b11;
      req_valid  = '0;
      req_write  = '0;
      resp_ready = '0;
      for (int d = 0; d < 2; d++) begin
         req_addr[d]  = '0;
         req_wdata[d] = '0;
      end

      // Reset held for two edges
      repeat (2) @(posedge clock);
      #1;
      rst = 2'b00;
      for (int d = 0; d < 2; d++) begin
         check("rst_req_ready", 32'(o_req_ready[d]), 32'd1);
         check("rst_resp_valid", 32'(o_resp_valid[d]), 32'd0);
         check("rst_resp_rdata", 32'(o_rdata[d]), 32'd0);
         check("rst_resp_error", 32'(o_resp_error[d]), 32'd0);
      end

      // Write then read back
      txn(0, 1'b1, 16'h0010, 16'hBEEF, 0);
      txn(0, 1'b0, 16'h0010, 16'h0000, 0);

      // Out of range: no write, no aliasing onto low addresses
      txn(0, 1'b1, 16'h0000, 16'h5A5A, 0);
      txn(0, 1'b1, 16'h4000, 16'h1234, 0);
      txn(0, 1'b0, 16'h0000, 16'h0000, 0);
      txn(0, 1'b0, 16'hFFFF, 16'h0000, 0);
      txn(0, 1'b1, 16'h3FFF, 16'h7E57, 1);
      txn(0, 1'b0, 16'h3FFF, 16'h0000, 0);

      // Backpressure with a new request waiting
      issue(0, 1'b0, 16'h0010, 16'h0000);
      collect(0, 3, 16'hBEEF, 1'b0, 1'b1, 5, 1'b1, 16'h0000);
      collect(0, 3, 16'h5A5A, 1'b0, 1'b1, 0, 1'b0, 16'h0000);

      // Zero wait states
      txn(1, 1'b1, 16'h0001, 16'h1111, 0);
      txn(1, 1'b1, 16'h0002, 16'h2222, 0);
      txn(1, 1'b0, 16'h0001, 16'h0000, 0);
      txn(1, 1'b0, 16'h0002, 16'h0000, 0);

      // Reset during the wait: the write must never land
      txn(0, 1'b1, 16'h0020, 16'h3333, 0);
      issue(0, 1'b1, 16'h0020, 16'hAAAA);
      rst[0] = 1'b1;
      @(posedge clock);
      #1;
      rst[0] = 1'b0;
      check("midrst_req_ready", 32'(o_req_ready[0]), 32'd1);
      check("midrst_resp_valid", 32'(o_resp_valid[0]), 32'd0);
      repeat (4) @(posedge clock);
      #1;
      check("midrst_quiet", 32'(o_resp_valid[0]), 32'd0);
      txn(0, 1'b0, 16'h0020, 16'h0000, 0);

      // Random traffic, stray resp_ready pulses while idle are ignored
      pool = '{16'h0000, 16'h0001, 16'h0002, 16'h0010, 16'h0020, 16'h3FFF, 16'h4000,
               16'hFFFF, 16'h1234};
      for (int i = 0; i < 80; i++) begin
         int d;
         logic [15:0] a;
         d = i % 2;
         a = pool[$urandom_range(0, 8)];
         if ($urandom_range(0, 3) == 0) a = 16'($urandom);
         if ($urandom_range(0, 4) == 0) begin
            resp_ready[d] = 1'b1;
            @(posedge clock);
            #1;
            resp_ready[d] = 1'b0;
            check("stray_resp_ready", 32'(o_resp_valid[d]), 32'd0);
         end
         txn(d, 1'($urandom), a, 16'($urandom), int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
